bidir_bus_master: RTL and testbench
===================================

// Module: bidir_bus_master
// PURPOSE
//  Transaction sequencer for the external 14-bit address / 8-bit bidirectional
//  data bus. It drives the logical side of the pin_bidir_8 data pins (o, dir,
//  sampling i) and the pin_bidir_14 address pins, plus the active-low strobes.
//  It turns single read/write requests into timed bus cycles, with a turnaround
//  so the FPGA and the device never drive the data bus at the same time.
// PARAMETERS
//  SETUP_CYCLES  1  Cycles addr/data are stable before strobe asserts (1..15).
//  STROBE_CYCLES 2  Cycles rd_n/wr_n are held low (1..15).
//  TURN_CYCLES   1  Cycles dir is 0 after a write before the next request (1..15).
//  WAIT_MAX      8  Extra strobe cycles allowed under BIDIR_BUS_WAIT_EN (1..255).
// PORTS
//  clk         in   1   System clock; everything is on the rising edge.
//  rst_n       in   1   Asynchronous active-low reset.
//  req_valid   in   1   Request present.
//  req_ready   out  1   High in IDLE only; a transfer is accepted when valid && ready.
//  req_write   in   1   1 = write, 0 = read.
//  req_addr    in   14  Bus address.
//  req_wdata   in   8   Write data.
//  rsp_valid   out  1   One-cycle pulse: read data is valid.
//  rsp_rdata   out  8   Read data; holds its value until the next read completes.
//  bus_addr    out  14  To the address pins.
//  bus_dout    out  8   To the data pin outputs (pin_bidir_8 .o).
//  bus_din     in   8   From the data pin inputs (pin_bidir_8 .i).
//  bus_dir     out  1   Data direction: 1 = FPGA drives, 0 = input.
//  bus_rd_n    out  1   Read strobe, active low.
//  bus_wr_n    out  1   Write strobe, active low.
// BEHAVIOUR
//  - Reset values (asynchronous, while rst_n is low): state=IDLE, bus_dir=0,
//    bus_rd_n=1, bus_wr_n=1, bus_addr=0, bus_dout=0, rsp_valid=0, rsp_rdata=0.
//  - req_ready is combinational: (state==IDLE).
//  - Pin outputs are all registered; no glitches on the strobes.
//  - States: IDLE -> SETUP -> STROBE -> HOLD -> (write: TURN -> IDLE | read: IDLE).
//  - On accept (cycle 0): latch addr, wdata and write, then go to SETUP.
//  - SETUP (SETUP_CYCLES cycles): bus_addr is valid. For a write, bus_dir=1
//    and bus_dout=wdata. Both strobes are high.
//  - STROBE (STROBE_CYCLES cycles): bus_wr_n=0 for a write, bus_rd_n=0 for a
//    read. addr, dout and dir are unchanged.
//  - Read sample: bus_din is captured into rsp_rdata on the clock edge that
//    ends the last STROBE cycle.
//  - HOLD (1 cycle): strobes are high; addr and dout are held. For a write,
//    bus_dir stays 1. For a read, rsp_valid=1 in this cycle.
//  - TURN (writes only, TURN_CYCLES cycles): bus_dir=0; bus_addr and bus_dout
//    are held.
//  - Total cycles from accept to the next ready:
//    write = SETUP+STROBE+1+TURN+1; read = SETUP+STROBE+1+1.
//  - bus_dir is never 1 while bus_rd_n is 0, and never 1 during a read.
//  - bus_rd_n and bus_wr_n are never low at the same time.
//  - Only one cycle counter is used; it is 8 bits wide and reloads on every
//    state entry. req inputs are ignored outside IDLE.
//  - Reset mid-transfer: abort immediately to the reset values; no rsp_valid.
// CONFIGURATION
//  - BIDIR_BUS_WAIT_EN defined:
//    - Adds input bus_wait (1 bit, active high, from the device) and output
//      rsp_err (1 bit).
//    - In the last STROBE cycle, if bus_wait==1, STROBE is extended one cycle
//      at a time, for at most WAIT_MAX extra cycles.
//    - If bus_wait is still 1 after WAIT_MAX extra cycles: go to HOLD with
//      rsp_err=1 for the HOLD cycle. A read then also pulses rsp_valid, and
//      rsp_rdata is the value sampled in the last cycle.
//    - rsp_err resets to 0.
//  - BIDIR_BUS_WAIT_EN undefined: no bus_wait or rsp_err ports; timing is fixed.
// TESTING (defaults S=1, P=2, T=1; cycle 0 = accept edge)
//  1. Write addr 0x1234, data 0xA5:
//     - c1: dir=1, addr=0x1234, dout=0xA5, wr_n=1.
//     - c2-3: wr_n=0.
//     - c4: wr_n=1, dir=1.
//     - c5: dir=0.
//     - c6: ready=1.
//  2. Read addr 0x0ABC, bus_din=0x5A during c3:
//     - dir=0 throughout; rd_n=0 in c2-3.
//     - c4: rsp_valid=1, rsp_rdata=0x5A.
//     - c5: ready=1.
//  3. Back-to-back write, read, write with req_valid held high:
//     - Accepts at c0, c6, c11.
//     - No cycle has dir=1 with rd_n=0; rsp_valid pulses exactly once.
//  4. Drop rst_n during c2 of a write:
//     - Same cycle: wr_n=1, dir=0, addr=0, ready=1.
//     - No rsp_valid afterwards.
//  5. Set S=3, P=4, T=2; write then read:
//     - Write: 11 cycles accept-to-ready; wr_n low for exactly 4 cycles.
//     - Read: 9 cycles accept-to-ready.
//  6. With BIDIR_BUS_WAIT_EN:
//     - Read with bus_wait=1 for 3 cycles: rd_n low 5 cycles, rsp_err=0.
//     - bus_wait stuck at 1: rd_n low 2+8 cycles, then rsp_valid=1, rsp_err=1.

Source files
------------

// File: rtl/bidir_bus_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bidir_bus_master
//
// Purpose:
//   Sequences single read/write requests onto an external bus with a 14-bit
//   address and an 8-bit bidirectional data bus. Each transfer runs the phases
//   SETUP -> STROBE -> HOLD, and writes add TURN. TURN gives the data pins a
//   turnaround with the FPGA released before the next request can start, so
//   the FPGA and the device never drive the data bus together. All pin-side
//   outputs are registered, so the strobes are glitch-free.
//
// Optional feature (macro BIDIR_BUS_WAIT_EN):
//   Adds the bus_wait input and the rsp_err output. A device can stretch the
//   strobe phase by up to WAIT_MAX cycles. If bus_wait is still high after
//   that, the transfer ends and rsp_err is high for the HOLD cycle.
//
// Parameters:
//   SETUP_CYCLES  (1..15)  cycles addr/data are stable before the strobe
//   STROBE_CYCLES (1..15)  cycles the strobe is held low
//   TURN_CYCLES   (1..15)  cycles dir is 0 after a write before IDLE
//   WAIT_MAX      (1..255) maximum extra strobe cycles under bus_wait
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_write/addr/wdata   request contents
//   rsp_valid, rsp_rdata   read completion pulse and held read data
//   bus_addr, bus_dout     address pins, data pin outputs
//   bus_din                data pin inputs
//   bus_dir                1 = FPGA drives the data pins
//   bus_rd_n, bus_wr_n     active-low strobes
//   bus_wait, rsp_err      only with BIDIR_BUS_WAIT_EN
// -----------------------------------------------------------------------------
module bidir_bus_master #(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int TURN_CYCLES   = 1,
   parameter int WAIT_MAX      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [13:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
`ifdef BIDIR_BUS_WAIT_EN
   input  logic        bus_wait,
   output logic        rsp_err,
`endif
   output logic [13:0] bus_addr,
   output logic [7:0]  bus_dout,
   input  logic [7:0]  bus_din,
   output logic        bus_dir,
   output logic        bus_rd_n,
   output logic        bus_wr_n
);

   // The single cycle counter is loaded with N-1 on entering a phase and
   // counts down to 0, so the phase lasts N cycles.
   localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] TURN_LD   = 8'(TURN_CYCLES - 1);
`ifdef BIDIR_BUS_WAIT_EN
   localparam logic [7:0] WAIT_LD   = 8'(WAIT_MAX - 1);
`endif

   generate
      if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
         $error("SETUP_CYCLES must be 1..15");
      end
      if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
         $error("STROBE_CYCLES must be 1..15");
      end
      if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
         $error("TURN_CYCLES must be 1..15");
      end
      if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait
         $error("WAIT_MAX must be 1..255");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      TURN
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic        wr_q, wr_nxt;
   logic [13:0] addr_nxt;
   logic [7:0]  dout_nxt;
   logic        dir_nxt;
   logic        rd_n_nxt;
   logic        wr_n_nxt;
   logic        rv_nxt;
   logic [7:0]  rdata_nxt;
   logic        enter_hold;
`ifdef BIDIR_BUS_WAIT_EN
   // Set while the strobe phase is being stretched. The counter is then
   // reused to count the extra cycles that remain.
   logic        wait_q, wait_nxt;
   logic        err_nxt;
`endif

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         wr_q      <= 1'b0;
         bus_addr  <= 14'd0;
         bus_dout  <= 8'd0;
         bus_dir   <= 1'b0;
         bus_rd_n  <= 1'b1;
         bus_wr_n  <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'd0;
`ifdef BIDIR_BUS_WAIT_EN
         wait_q    <= 1'b0;
         rsp_err   <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wr_q      <= wr_nxt;
         bus_addr  <= addr_nxt;
         bus_dout  <= dout_nxt;
         bus_dir   <= dir_nxt;
         bus_rd_n  <= rd_n_nxt;
         bus_wr_n  <= wr_n_nxt;
         rsp_valid <= rv_nxt;
         rsp_rdata <= rdata_nxt;
`ifdef BIDIR_BUS_WAIT_EN
         wait_q    <= wait_nxt;
         rsp_err   <= err_nxt;
`endif
      end
   end

   // Pin outputs are computed for the state being entered, so they switch on
   // the same edge as the state register.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      wr_nxt     = wr_q;
      addr_nxt   = bus_addr;
      dout_nxt   = bus_dout;
      dir_nxt    = bus_dir;
      rd_n_nxt   = 1'b1;
      wr_n_nxt   = 1'b1;
      rv_nxt     = 1'b0;
      rdata_nxt  = rsp_rdata;
      enter_hold = 1'b0;
`ifdef BIDIR_BUS_WAIT_EN
      wait_nxt   = wait_q;
      err_nxt    = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
               wr_nxt    = req_write;
               addr_nxt  = req_addr;
               dout_nxt  = req_wdata;
               dir_nxt   = req_write;
            end
         end

         SETUP: begin
            if (cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else begin
               state_nxt = STROBE;
               cnt_nxt   = STROBE_LD;
               rd_n_nxt  = wr_q;
               wr_n_nxt  = ~wr_q;
            end
         end

         STROBE: begin
            rd_n_nxt = wr_q;
            wr_n_nxt = ~wr_q;
`ifdef BIDIR_BUS_WAIT_EN
            if (!wait_q && cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else if (bus_wait && !(wait_q && cnt == 8'd0)) begin
               // Stretch the strobe by one cycle. The first stretch loads the
               // extra-cycle budget.
               wait_nxt = 1'b1;
               cnt_nxt  = wait_q ? cnt - 8'd1 : WAIT_LD;
            end else begin
               enter_hold = 1'b1;
               err_nxt    = bus_wait;  // still waiting means the budget ran out
            end
`else
            if (cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else begin
               enter_hold = 1'b1;
            end
`endif
            if (enter_hold) begin
               state_nxt = HOLD;
               cnt_nxt   = 8'd0;
               rd_n_nxt  = 1'b1;
               wr_n_nxt  = 1'b1;
`ifdef BIDIR_BUS_WAIT_EN
               wait_nxt  = 1'b0;
`endif
               if (!wr_q) begin
                  rv_nxt    = 1'b1;
                  rdata_nxt = bus_din;
               end
            end
         end

         HOLD: begin
            if (wr_q) begin
               state_nxt = TURN;
               cnt_nxt   = TURN_LD;
               dir_nxt   = 1'b0;   // release the data pins before the next request
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end
         end

         TURN: begin
            if (cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            dir_nxt   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bidir_bus_master.sv
`timescale 1ns/1ps
module tb_bidir_bus_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_write;
   logic [13:0] req_addr;
   logic [7:0]  req_wdata, bus_din;
   logic        req_ready, rsp_valid;
   logic [7:0]  rsp_rdata, bus_dout;
   logic [13:0] bus_addr;
   logic        bus_dir, bus_rd_n, bus_wr_n;

   // second instance with S=3, P=4, T=2, sharing the request fields
   logic        req_valid2, req_ready2, rsp_valid2;
   logic [7:0]  rsp_rdata2, bus_dout2;
   logic [13:0] bus_addr2;
   logic        bus_dir2, bus_rd_n2, bus_wr_n2;
`ifdef BIDIR_BUS_WAIT_EN
   logic        bus_wait, rsp_err, rsp_err2;
`endif

   always #5 clk = ~clk;

   bidir_bus_master dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef BIDIR_BUS_WAIT_EN
      .bus_wait(bus_wait), .rsp_err(rsp_err),
`endif
      .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
      .bus_dir(bus_dir), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n)
   );

   bidir_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .TURN_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
`ifdef BIDIR_BUS_WAIT_EN
      .bus_wait(bus_wait), .rsp_err(rsp_err2),
`endif
      .bus_addr(bus_addr2), .bus_dout(bus_dout2), .bus_din(bus_din),
      .bus_dir(bus_dir2), .bus_rd_n(bus_rd_n2), .bus_wr_n(bus_wr_n2)
   );

   int n_tot = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct packed {
      logic        wr;
      logic [13:0] addr;
      logic [7:0]  data;
   } bus_t;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } rsp_t;

   bus_t bus_q[$];
   rsp_t rsp_q[$];

   // scoreboard monitor for dut
   bus_t mon_b;
   rsp_t mon_r;
   logic wr_n_d = 1'b1;
   logic rd_n_d = 1'b1;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (!bus_rd_n || !bus_wr_n) begin
            chk("inv_dir_with_rd", {31'd0, bus_dir & ~bus_rd_n}, 32'd0);
            chk("inv_both_strobes", {31'd0, ~bus_rd_n & ~bus_wr_n}, 32'd0);
         end
         if ((!bus_wr_n && wr_n_d) || (!bus_rd_n && rd_n_d)) begin
            if (bus_q.size() == 0) begin
               n_tot++;
               $display("FAIL bus_unexpected: strobe at addr 0x%0h, no transfer expected", bus_addr);
            end else begin
               mon_b = bus_q.pop_front();
               chk("bus_kind", {31'd0, ~bus_wr_n}, {31'd0, mon_b.wr});
               chk("bus_addr", {18'd0, bus_addr}, {18'd0, mon_b.addr});
               chk("bus_dir", {31'd0, bus_dir}, {31'd0, mon_b.wr});
               if (mon_b.wr) chk("bus_dout", {24'd0, bus_dout}, {24'd0, mon_b.data});
            end
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               n_tot++;
               $display("FAIL rsp_unexpected: rsp_valid=1 rdata=0x%0h, none expected", rsp_rdata);
            end else begin
               mon_r = rsp_q.pop_front();
               chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_r.data});
`ifdef BIDIR_BUS_WAIT_EN
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_r.err});
`endif
            end
         end
      end
      wr_n_d <= bus_wr_n;
      rd_n_d <= bus_rd_n;
   end

   task automatic issue(input logic wr, input logic [13:0] a, input logic [7:0] d);
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 40);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lo, pv;
      rst_n = 1'b0;
      req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; bus_din = 8'h00;
`ifdef BIDIR_BUS_WAIT_EN
      bus_wait = 1'b0;
`endif
      // reset values
      @(negedge clk);
      chk("rst_dir", bus_dir, 0);
      chk("rst_rd_n", bus_rd_n, 1);
      chk("rst_wr_n", bus_wr_n, 1);
      chk("rst_addr", bus_addr, 0);
      chk("rst_dout", bus_dout, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: write 0x1234 <= 0xA5
      chk("t1_ready_idle", req_ready, 1);
      bus_q.push_back('{1'b1, 14'h1234, 8'hA5});
      issue(1'b1, 14'h1234, 8'hA5);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk); // c1
      chk("t1_c1_dir", bus_dir, 1);
      chk("t1_c1_addr", bus_addr, 14'h1234);
      chk("t1_c1_dout", bus_dout, 8'hA5);
      chk("t1_c1_wr_n", bus_wr_n, 1);
      chk("t1_c1_ready", req_ready, 0);
      @(negedge clk); // c2
      chk("t1_c2_wr_n", bus_wr_n, 0);
      @(negedge clk); // c3
      chk("t1_c3_wr_n", bus_wr_n, 0);
      @(negedge clk); // c4
      chk("t1_c4_wr_n", bus_wr_n, 1);
      chk("t1_c4_dir", bus_dir, 1);
      @(negedge clk); // c5
      chk("t1_c5_dir", bus_dir, 0);
      chk("t1_c5_addr", bus_addr, 14'h1234);
      chk("t1_c5_ready", req_ready, 0);
      @(negedge clk); // c6
      chk("t1_c6_ready", req_ready, 1);

      // 2: read 0x0ABC, device returns 0x5A in c3
      bus_q.push_back('{1'b0, 14'h0ABC, 8'h00});
      rsp_q.push_back('{8'h5A, 1'b0});
      issue(1'b0, 14'h0ABC, 8'h00);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk); // c1
      chk("t2_c1_dir", bus_dir, 0);
      chk("t2_c1_rd_n", bus_rd_n, 1);
      chk("t2_c1_addr", bus_addr, 14'h0ABC);
      @(negedge clk); // c2
      chk("t2_c2_rd_n", bus_rd_n, 0);
      chk("t2_c2_dir", bus_dir, 0);
      @(negedge clk); // c3
      chk("t2_c3_rd_n", bus_rd_n, 0);
      bus_din = 8'h5A;
      @(negedge clk); // c4
      bus_din = 8'h11;
      chk("t2_c4_rsp_valid", rsp_valid, 1);
      chk("t2_c4_rd_n", bus_rd_n, 1);
      chk("t2_c4_dir", bus_dir, 0);
      @(negedge clk); // c5
      chk("t2_c5_ready", req_ready, 1);
      chk("t2_c5_rsp_valid", rsp_valid, 0);
      chk("t2_c5_rdata_held", rsp_rdata, 8'h5A);

      // 3: back-to-back write, read, write with req_valid held
      bus_din = 8'hC3;
      bus_q.push_back('{1'b1, 14'h0001, 8'h3C});
      bus_q.push_back('{1'b0, 14'h0002, 8'h00});
      bus_q.push_back('{1'b1, 14'h0003, 8'h7E});
      rsp_q.push_back('{8'hC3, 1'b0});
      issue(1'b1, 14'h0001, 8'h3C);
      @(posedge clk); #1 issue(1'b0, 14'h0002, 8'h00);
      wait_ready(n);
      chk("t3_accept2_at_c6", n, 6);
      @(posedge clk); #1 issue(1'b1, 14'h0003, 8'h7E);
      wait_ready(n);
      chk("t3_accept3_at_c11", n, 5);
      @(posedge clk); #1 req_valid = 1'b0;
      wait_ready(n);
      chk("t3_last_write_len", n, 6);
      chk("t3_rdata", rsp_rdata, 8'hC3);

      // 4: reset during c2 of a write
      bus_q.push_back('{1'b1, 14'h2AAA, 8'h55});
      issue(1'b1, 14'h2AAA, 8'h55);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk); // c1
      @(negedge clk); // c2
      chk("t4_c2_wr_n", bus_wr_n, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("t4_rst_wr_n", bus_wr_n, 1);
      chk("t4_rst_dir", bus_dir, 0);
      chk("t4_rst_addr", bus_addr, 0);
      chk("t4_rst_dout", bus_dout, 0);
      chk("t4_rst_ready", req_ready, 1);
      chk("t4_rst_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("t4_idle_after", req_ready, 1);

      // 5: S=3, P=4, T=2 instance
      chk("t5_ready", req_ready2, 1);
      req_write = 1'b1; req_addr = 14'h0777; req_wdata = 8'hE1; req_valid2 = 1'b1;
      @(posedge clk); #1 req_valid2 = 1'b0;
      n = 0; lo = 0;
      do begin
         @(negedge clk);
         n++;
         if (!bus_wr_n2) lo++;
      end while (!req_ready2 && n < 60);
      chk("t5_wr_cycles", n, 11);
      chk("t5_wr_low", lo, 4);
      bus_din = 8'h96;
      req_write = 1'b0; req_addr = 14'h0778; req_valid2 = 1'b1;
      @(posedge clk); #1 req_valid2 = 1'b0;
      n = 0; lo = 0; pv = 0;
      do begin
         @(negedge clk);
         n++;
         if (!bus_rd_n2) lo++;
         if (rsp_valid2) pv++;
      end while (!req_ready2 && n < 60);
      chk("t5_rd_cycles", n, 9);
      chk("t5_rd_low", lo, 4);
      chk("t5_rd_pulses", pv, 1);
      chk("t5_rd_data", rsp_rdata2, 8'h96);

`ifdef BIDIR_BUS_WAIT_EN
      // 6a: read stretched by bus_wait for 3 cycles
      bus_din = 8'h42;
      bus_q.push_back('{1'b0, 14'h0100, 8'h00});
      rsp_q.push_back('{8'h42, 1'b0});
      issue(1'b0, 14'h0100, 8'h00);
      @(posedge clk); #1 req_valid = 1'b0;
      n = 0; lo = 0;
      do begin
         @(negedge clk);
         n++;
         if (!bus_rd_n) lo++;
         if (n == 2) bus_wait = 1'b1;
         if (n == 6) bus_wait = 1'b0;
      end while (!req_ready && n < 40);
      chk("t6a_rd_low", lo, 5);
      chk("t6a_cycles", n, 8);

      // 6b: bus_wait stuck high
      bus_din = 8'h24;
      bus_wait = 1'b1;
      bus_q.push_back('{1'b0, 14'h0200, 8'h00});
      rsp_q.push_back('{8'h24, 1'b1});
      issue(1'b0, 14'h0200, 8'h00);
      @(posedge clk); #1 req_valid = 1'b0;
      n = 0; lo = 0;
      do begin
         @(negedge clk);
         n++;
         if (!bus_rd_n) lo++;
      end while (!req_ready && n < 40);
      bus_wait = 1'b0;
      chk("t6b_rd_low", lo, 10);
      chk("t6b_cycles", n, 13);
`endif

      repeat (3) @(negedge clk);
      chk("bus_q_empty", bus_q.size(), 0);
      chk("rsp_q_empty", rsp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
